// File: rtl/adc_pkg.sv
// Shared definitions for the SPI ADC capture controller.
// State encodings, default geometry and width helpers.
package adc_pkg;

   localparam int ADC_WIDTH  = 12;
   localparam int FRAME_BITS = 16;
   localparam int CLK_DIV    = 4;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SETUP    = 3'd1;
   localparam logic [2:0] ST_TRANSFER = 3'd2;
   localparam logic [2:0] ST_LOAD     = 3'd3;
   localparam logic [2:0] ST_QUIET    = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE     = ST_IDLE,
      S_SETUP    = ST_SETUP,
      S_TRANSFER = ST_TRANSFER,
      S_LOAD     = ST_LOAD,
      S_QUIET    = ST_QUIET
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r = r + 1;
      return r;
   endfunction

   // Counter width that never collapses to zero bits.
   function automatic int cw(input int v);
      return (clog2(v) < 1) ? 1 : clog2(v);
   endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock generator: phase/bit counters and SCLK strobes.
// Counters and SCLK are held at zero whenever en_i is low.
module adc_sclk_gen
   import adc_pkg::*;
#(
   parameter int FrameBits = FRAME_BITS,
   parameter int ClkDiv    = CLK_DIV
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   output logic sclk_o,
   output logic rise_o,
   output logic frame_end_o
);

   localparam int PW = cw(ClkDiv);
   localparam int BW = cw(FrameBits + 1);
   localparam logic [PW-1:0] PH_LAST  = PW'(ClkDiv - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(FrameBits - 1);

   logic [PW-1:0] phase;
   logic [BW-1:0] bit_cnt;
   logic          ph_end;

   assign ph_end      = en_i && (phase == PH_LAST);
   assign rise_o      = ph_end && !sclk_o;
   assign frame_end_o = ph_end && sclk_o && (bit_cnt == BIT_LAST);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase   <= '0;
         bit_cnt <= '0;
         sclk_o  <= 1'b0;
      end else if (!en_i || frame_end_o) begin
         phase   <= '0;
         bit_cnt <= '0;
         sclk_o  <= 1'b0;
      end else if (ph_end) begin
         phase  <= '0;
         sclk_o <= !sclk_o;
         if (sclk_o) bit_cnt <= bit_cnt + 1'b1;
      end else begin
         phase <= phase + 1'b1;
      end
   end

endmodule

// File: rtl/adc_capture_ctrl.sv
// One SPI ADC conversion per accepted request, with a load pulse
// for the capture register and a completion pulse afterwards.
module adc_capture_ctrl
   import adc_pkg::*;
#(
   parameter int Width     = ADC_WIDTH,
   parameter int FrameBits = FRAME_BITS,
   parameter int ClkDiv    = CLK_DIV
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             miso_i,
   output logic             cs_no,
   output logic             sclk_o,
   output logic [Width-1:0] data_o,
   output logic             hab_o,
   output logic             busy_o,
   output logic             done_o
);

   localparam int CW = cw(2 * ClkDiv);
   localparam logic [CW-1:0] SETUP_LAST = CW'(ClkDiv - 1);
   localparam logic [CW-1:0] QUIET_LAST = CW'(2 * ClkDiv - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [Width-1:0] shreg;
   logic             sclk_en;
   logic             rise;
   logic             frame_end;

   assign sclk_en = (state == S_TRANSFER);
   assign data_o  = shreg;

   adc_sclk_gen #(
      .FrameBits (FrameBits),
      .ClkDiv    (ClkDiv)
   ) u_sclk (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .en_i        (sclk_en),
      .sclk_o      (sclk_o),
      .rise_o      (rise),
      .frame_end_o (frame_end)
   );

   // Only the newest Width bits are kept; leading bits fall off the top.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= S_IDLE;
         cnt    <= '0;
         shreg  <= '0;
         cs_no  <= 1'b1;
         hab_o  <= 1'b0;
         done_o <= 1'b0;
         busy_o <= 1'b0;
      end else begin
         hab_o  <= 1'b0;
         done_o <= 1'b0;
         if (rise) shreg <= {shreg[Width-2:0], miso_i};
         unique case (state)
            S_IDLE: begin
               if (start_i) begin
                  state  <= S_SETUP;
                  cnt    <= '0;
                  cs_no  <= 1'b0;
                  busy_o <= 1'b1;
               end
            end
            S_SETUP: begin
               if (cnt == SETUP_LAST) begin
                  state <= S_TRANSFER;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_TRANSFER: begin
               if (frame_end) begin
                  state <= S_LOAD;
                  cs_no <= 1'b1;
                  hab_o <= 1'b1;
               end
            end
            S_LOAD: begin
               state  <= S_QUIET;
               cnt    <= '0;
               done_o <= 1'b1;
            end
            S_QUIET: begin
               if (cnt == QUIET_LAST) begin
                  state  <= S_IDLE;
                  cnt    <= '0;
                  busy_o <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state  <= S_IDLE;
               cnt    <= '0;
               cs_no  <= 1'b1;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
